// File: rtl/dsc_par_stream_decoder.sv
// Framed stochastic-stream decoder: counts the 1s across LANES bits per accepted
// beat for a programmed number of beats, then holds the saturated count until consumed.
module dsc_par_stream_decoder #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] frame_cycles,
  input  logic                 bs_valid,
  input  logic [LANES-1:0]     bs_data,
  output logic                 bs_ready,
  output logic [WIDTH-1:0]     bin_data,
  output logic                 bin_valid,
  input  logic                 bin_ready,
  output logic                 overflow,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int PC_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] remaining, remaining_next;
  logic [WIDTH-1:0]     acc, acc_next;
  logic                 ovf, ovf_next;
  logic [PC_W-1:0]      beat_ones;
  logic [WIDTH:0]       sum;
  logic                 beat_acc;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. bs_ready depends only on state; bin_valid holds with stable data until taken.
  assign bs_ready  = (state == ST_ACCUM);
  assign bin_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);
  assign bin_data  = acc;
  assign overflow  = ovf;
  assign state_dbg = state;

  assign beat_acc = bs_valid & bs_ready;

  always_comb begin
    beat_ones = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_ones = beat_ones + PC_W'(bs_data[i]);
    end
  end

  // One extra bit catches any carry past the accumulator range.
  assign sum = {1'b0, acc} + (WIDTH + 1)'(beat_ones);

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    acc_next       = acc;
    ovf_next       = ovf;
    case (state)
      ST_IDLE: begin
        if (start) begin
          acc_next       = '0;
          ovf_next       = 1'b0;
          remaining_next = frame_cycles;
          state_next     = (frame_cycles == '0) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat_acc) begin
          if (sum[WIDTH]) begin
            acc_next = '1;
            ovf_next = 1'b1;
          end else begin
            acc_next = sum[WIDTH-1:0];
          end
          remaining_next = remaining - CNT_WIDTH'(1);
          if (remaining == CNT_WIDTH'(1)) begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bin_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      acc       <= acc_next;
      ovf       <= ovf_next;
    end
  end

endmodule

// File: tb/tb_dsc_par_stream_decoder.sv
// Randomized scoreboard bench for dsc_par_stream_decoder; a frame-level reference
// model computes each expected count and overflow from the whole beat list.
module tb_dsc_par_stream_decoder;

  localparam int LANES     = 4;
  localparam int WIDTH     = 6;
  localparam int CNT_WIDTH = 8;
  localparam int MAXV      = (1 << WIDTH) - 1;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [CNT_WIDTH-1:0] frame_cycles;
  logic                 bs_valid;
  logic [LANES-1:0]     bs_data;
  logic                 bs_ready;
  logic [WIDTH-1:0]     bin_data;
  logic                 bin_valid;
  logic                 bin_ready;
  logic                 overflow;
  logic                 busy;
  logic [1:0]           state_dbg;

  dsc_par_stream_decoder #(
    .LANES(LANES), .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_cycles(frame_cycles),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
    .bin_data(bin_data), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH:0]   exp_q[$];
  logic [LANES-1:0] beat_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: total ones over the frame, clamped; overflow iff total exceeds range.
  function automatic logic [WIDTH:0] model_result();
    int total;
    logic [WIDTH:0] r;
    total = 0;
    foreach (beat_q[i]) total += $countones(beat_q[i]);
    if (total > MAXV) r = {1'b1, {WIDTH{1'b1}}};
    else              r = {1'b0, WIDTH'(total)};
    return r;
  endfunction

  task automatic add_beats(input int n, input logic [LANES-1:0] v);
    for (int i = 0; i < n; i++) beat_q.push_back(v);
  endtask

  task automatic add_random_beats(input int n);
    for (int i = 0; i < n; i++) beat_q.push_back(LANES'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bs_valid = 1'b0;
    bin_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_bs_ready", 32'(bs_ready), 0);
    check("rst_bin_valid", 32'(bin_valid), 0);
    check("rst_bin_data", 32'(bin_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
  endtask

  // driver: one complete frame from beat_q, then the result handshake
  task automatic run_frame(input int gap_min, input int gap_max, input int hold_cycles,
                           input bit poke_start);
    int n;
    n = beat_q.size();
    exp_q.push_back(model_result());
    start = 1'b1;
    frame_cycles = CNT_WIDTH'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(gap_min, gap_max);
      for (int g = 0; g < gap; g++) begin
        bs_valid = 1'b0;
        bs_data = LANES'($urandom);
        bin_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      check("bs_ready_accum", 32'(bs_ready), 1);
      check("no_early_valid", 32'(bin_valid), 0);
      bin_ready = 1'($urandom_range(0, 1));
      bs_valid = 1'b1;
      bs_data = beat_q[i];
      @(posedge clk); #1;
      bs_valid = 1'b0;
      bin_ready = 1'b0;
    end
    check("valid_after_last_beat", 32'(bin_valid), 1);
    check("bs_ready_hold", 32'(bs_ready), 0);
    for (int h = 0; h < hold_cycles; h++) begin
      if (poke_start && h == 0) begin
        start = 1'b1;
        frame_cycles = CNT_WIDTH'($urandom_range(1, 5));
      end
      bs_valid = 1'b1;
      bs_data = LANES'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      bs_valid = 1'b0;
      check("hold_valid", 32'(bin_valid), 1);
    end
    bin_ready = 1'b1;
    @(posedge clk); #1;
    bin_ready = 1'b0;
    check("idle_valid", 32'(bin_valid), 0);
    check("idle_busy", 32'(busy), 0);
    beat_q.delete();
  endtask

  // monitor / scoreboard
  logic             held = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic             held_ovf;

  always @(negedge clk) begin
    if (!rst && bin_valid) begin
      if (held) begin
        check("hold_data_stable", 32'(bin_data), 32'(held_data));
        check("hold_ovf_stable", 32'(overflow), 32'(held_ovf));
      end
      if (bin_ready) begin
        logic [WIDTH:0] e;
        check("result_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("bin_data", 32'(bin_data), 32'(e[WIDTH-1:0]));
          check("overflow", 32'(overflow), 32'(e[WIDTH]));
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_data = bin_data;
        held_ovf = overflow;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_cycles = '0;
    bs_valid = 1'b0;
    bs_data = '0;
    bin_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // full-rate frame: 8 beats of 4 ones
    add_beats(8, 4'b1111);
    run_frame(0, 0, 0, 1'b0);

    // sparse beats separated by idle cycles: 1+2+3+4
    beat_q.push_back(4'b0001);
    beat_q.push_back(4'b0011);
    beat_q.push_back(4'b0111);
    beat_q.push_back(4'b1111);
    run_frame(2, 2, 0, 1'b0);

    // saturation, then a fresh frame must clear overflow
    add_beats(20, 4'b1111);
    run_frame(0, 1, 1, 1'b0);
    add_beats(1, 4'b0001);
    run_frame(0, 0, 0, 1'b0);

    // empty frame
    run_frame(0, 0, 2, 1'b0);

    // long hold with an ignored start pulse
    add_random_beats(6);
    run_frame(0, 1, 5, 1'b1);

    // reset after 3 of 8 beats discards the partial frame
    start = 1'b1;
    frame_cycles = CNT_WIDTH'(8);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bs_valid = 1'b1;
      bs_data = 4'b1111;
      @(posedge clk); #1;
    end
    bs_valid = 1'b0;
    do_reset();
    add_beats(2, 4'b1010);
    run_frame(0, 0, 0, 1'b0);

    // longest legal frame
    add_beats((1 << CNT_WIDTH) - 1, 4'b0101);
    run_frame(0, 0, 1, 1'b0);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      add_random_beats($urandom_range(0, 30));
      run_frame(0, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
